// File: rtl/mem_pkg.sv
// Shared constants and encodings for the cache-to-memory block interface.
// Used by block_data_memory and by the cache controller above it.
package mem_pkg;

  localparam int BLOCK_ADDR_W = 6;
  localparam int BLOCK_DATA_W = 32;
  localparam int MEM_LATENCY  = 5;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mem_state_t;

endpackage

// File: rtl/block_data_memory_latency_counter.sv
// Down-counter that paces the memory access latency.
// Loads a start value, counts down while enabled, flags zero.
module latency_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             enable,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // load wins over decrement; count saturates at zero
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_value;
    end else if (enable && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/block_data_memory.sv
// Block-wide main memory behind the cache controller.
// Fixed-latency access with a busywait handshake.
module block_data_memory
  import mem_pkg::*;
#(
  parameter int ADDR_W  = BLOCK_ADDR_W,
  parameter int DATA_W  = BLOCK_DATA_W,
  parameter int LATENCY = MEM_LATENCY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              busywait
);

  localparam int DEPTH = 2 ** ADDR_W;

  mem_state_t        state_q;
  mem_state_t        state_d;
  logic              request;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_zero;
  logic              do_access;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              op_q;
  logic [DATA_W-1:0] mem [DEPTH];

  // both strobes at once is not a legal request
  assign request = read ^ write;

  latency_counter #(
    .CNT_W(4)
  ) u_cnt (
    .clock     (clock),
    .reset     (reset),
    .load      (cnt_load),
    .load_value(4'(LATENCY - 1)),
    .enable    (cnt_en),
    .zero      (cnt_zero)
  );

  // state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; the unused encoding falls back to IDLE
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = request ? BUSY : IDLE;
      BUSY:    state_d = cnt_zero ? DONE : BUSY;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // handshake and datapath strobes
  always_comb begin
    busywait  = 1'b0;
    cnt_load  = 1'b0;
    cnt_en    = 1'b0;
    do_access = 1'b0;
    case (state_q)
      BUSY: begin
        busywait  = 1'b1;
        cnt_en    = 1'b1;
        do_access = cnt_zero;
      end
      DONE: begin
        busywait = 1'b0;
      end
      default: begin
        busywait = request;
        cnt_load = request;
      end
    endcase
  end

  // request capture; later input changes are ignored
  always_ff @(posedge clock) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
    end else if (cnt_load) begin
      addr_q  <= address;
      wdata_q <= writedata;
      op_q    <= write ? OP_WRITE : OP_READ;
    end
  end

  // array update from captured values only
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_access && (op_q == OP_WRITE)) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // read result register, held until the next read completes
  always_ff @(posedge clock) begin
    if (!reset) begin
      readdata <= '0;
    end else if (do_access && (op_q == OP_READ)) begin
      readdata <= mem[addr_q];
    end
  end

endmodule

// File: doc/block_data_memory.md
# block_data_memory

Main-memory responder on the cache-to-memory block interface: serves whole-block (32-bit) read and write requests from the cache controller with a fixed multi-cycle access latency, signalled through a busywait handshake. Sits below the cache controller as its only memory target; holds 64 blocks, which is the full 256-byte data address space at 4 bytes per block.

## Interface
Parameters:
- ADDR_W, 6, block address width; depth = 2**ADDR_W blocks
- DATA_W, 32, block width in bits
- LATENCY, 5, cycles spent in BUSY per access; legal range 1..15

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on rising edge of clock
- read  in  1  block read request; held by requester until it samples busywait low
- write  in  1  block write request; same hold rule as read
- address  in  ADDR_W  block address, {tag, index} from requester
- writedata  in  DATA_W  block to store on write
- readdata  out  DATA_W  registered block from last completed read
- busywait  out  1  high while a request is accepted or in progress

## Operation
- States: IDLE, BUSY, DONE; encoded 2'b00, 2'b01, 2'b10; 2'b11 unreachable and treated as IDLE.
- IDLE: request = read XOR write.
  - busywait = request, combinationally, in the same cycle.
  - On the edge where request=1: capture address, writedata and op (read/write) into internal registers; cnt <= LATENCY-1; go to BUSY.
  - read and write both high: no access, busywait low, state stays IDLE.
- BUSY: busywait=1.
  - cnt != 0: cnt decrements.
  - cnt == 0 on the edge: perform the access using the captured values only; go to DONE.
    - Captured write: mem[addr_q] <= wdata_q.
    - Captured read: readdata <= mem[addr_q].
- DONE: busywait=0 for exactly one cycle; the inputs are ignored; go to IDLE unconditionally. The requester drops read/write during this cycle.
- readdata holds its value until the next read completes; writes never change it.
- Input changes during BUSY or DONE have no effect.
- Reset (reset=0 at an edge):
  - state <= IDLE; cnt <= 0; readdata <= 0; all mem words <= 0.
  - An in-flight access is aborted with no array update.
  - busywait is 0 in the cycle after reset, unless a request is present then, since busywait in IDLE is combinational.

## Timing
- The request is first seen in cycle 0.
- busywait is high in cycles 0..LATENCY. That is 1 cycle in IDLE plus LATENCY cycles in BUSY.
- DONE is cycle LATENCY+1. In that cycle busywait=0 and readdata is valid.
- Read-after-write to the same address: the earliest new request is in cycle LATENCY+2, the first IDLE cycle after DONE. It returns the new data.
- Back-to-back throughput: one access per LATENCY+2 cycles.
- Reset values: busywait=0 (no request present), readdata=0.

## Structure
- Shared package `mem_pkg` holds:
  - the state encodings IDLE/BUSY/DONE
  - BLOCK_ADDR_W=6, BLOCK_DATA_W=32, MEM_LATENCY=5
  - op encoding OP_READ=1'b0, OP_WRITE=1'b1
- The cache controller reads the same constants from `mem_pkg`.
- One sub-module is natural: `latency_counter`.
  - Inputs: load, load value LATENCY-1, enable.
  - Output: `zero` flag.
  - Synchronous active-low clear.
- The FSM, the capture registers and the array stay in `block_data_memory`.

## Test plan
- Reset, then write address 6'h05 data 32'hDEADBEEF, hold write until busywait=0 -> busywait high in cycles 0..5, low in cycle 6; mem[5]=32'hDEADBEEF.
- Read 6'h05 in cycle 8 -> busywait low in cycle 14; readdata=32'hDEADBEEF in cycle 14 and held afterwards.
- Read 6'h3F (never written) -> readdata=32'h0.
- Start a write of 32'h12345678 to 6'h0A, then change address/writedata to 6'h0B/32'hFFFFFFFF in cycle 2 -> mem[0A]=32'h12345678 and mem[0B]=0.
- Drive read and write high together for 3 cycles -> busywait=0 throughout, state IDLE, no array change.
- Start a write of 32'hCAFEF00D to 6'h01, assert reset=0 in cycle 3 -> in the cycle after the reset edge, state=IDLE, busywait=0, readdata=0; a later read of 6'h01 returns 32'h0.
